// File: rtl/present_pkg.sv
// PRESENT-80 shared types, S-box tables and combinational round helpers.
// Decryption helpers are only used when PRESENT_DEC_EN is defined.
package present_pkg;

  localparam int BLOCK_W = 64;
  localparam int KEY_W   = 80;
  localparam logic [4:0] ROUNDS = 5'd31;

  localparam logic [3:0] SBOX [16] = '{
    4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
    4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
  };

  localparam logic [3:0] SBOX_INV [16] = '{
    4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
    4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA
  };

  typedef enum logic [2:0] {
    LOAD, KEYEXP, XOR0, ROUND, FINAL, DONE
  } fsm_e;

  function automatic logic [63:0] s_layer(input logic [63:0] d);
    logic [63:0] q;
    q = '0;
    for (int i = 0; i < 16; i++) q[6'(4 * i) +: 4] = SBOX[d[6'(4 * i) +: 4]];
    return q;
  endfunction

  function automatic logic [63:0] s_inv_layer(input logic [63:0] d);
    logic [63:0] q;
    q = '0;
    for (int i = 0; i < 16; i++) q[6'(4 * i) +: 4] = SBOX_INV[d[6'(4 * i) +: 4]];
    return q;
  endfunction

  // bit i lands on 16*i mod 63; bit 63 never moves
  function automatic logic [63:0] p_layer(input logic [63:0] d);
    logic [63:0] q;
    q = '0;
    for (int i = 0; i < 63; i++) q[6'((16 * i) % 63)] = d[6'(i)];
    q[63] = d[63];
    return q;
  endfunction

  function automatic logic [63:0] p_inv_layer(input logic [63:0] d);
    logic [63:0] q;
    q = '0;
    for (int i = 0; i < 63; i++) q[6'(i)] = d[6'((16 * i) % 63)];
    q[63] = d[63];
    return q;
  endfunction

  function automatic logic [79:0] key_upd(input logic [79:0] k, input logic [4:0] r);
    logic [79:0] t;
    t = {k[18:0], k[79:19]};
    t[79:76] = SBOX[t[79:76]];
    t[19:15] = t[19:15] ^ r;
    return t;
  endfunction

  function automatic logic [79:0] key_inv(input logic [79:0] k, input logic [4:0] r);
    logic [79:0] t;
    t = k;
    t[19:15] = t[19:15] ^ r;
    t[79:76] = SBOX_INV[t[79:76]];
    return {t[60:0], t[79:61]};
  endfunction

endpackage

// File: rtl/present80_core_if.sv
// Operand/result bundle between the test harness (master) and the cipher core (slave).
interface present80_core_if;
  logic [63:0] block_i;
  logic [79:0] key_i;
  logic        encdec_i;
  logic [63:0] block_o;
  logic        end_enc;
  logic        end_dec;

  modport master (output block_i, key_i, encdec_i, input block_o, end_enc, end_dec);
  modport slave  (input block_i, key_i, encdec_i, output block_o, end_enc, end_dec);
endinterface

// File: rtl/present80_key_sched.sv
// Key register and round counter; steps forward (encrypt/expand) or backward (decrypt).
// Backward stepping exists only when PRESENT_DEC_EN is defined.
module present80_key_sched
  import present_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               i_load,
  input  logic               i_fwd,
`ifdef PRESENT_DEC_EN
  input  logic               i_bwd,
  output logic [BLOCK_W-1:0] o_rk_inv,
`endif
  input  logic [KEY_W-1:0]   i_key,
  output logic [BLOCK_W-1:0] o_rk,
  output logic [4:0]         o_rnd
);

  logic [KEY_W-1:0] r_key;
  logic [4:0]       r_rnd;

`ifdef PRESENT_DEC_EN
  logic [KEY_W-1:0] w_key_inv;
  assign w_key_inv = key_inv(r_key, r_rnd);
  assign o_rk_inv  = w_key_inv[79:16];
`endif

  assign o_rk  = r_key[79:16];
  assign o_rnd = r_rnd;

  // counter saturates at ROUNDS so the decrypt pass starts from round 31
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_key <= '0;
      r_rnd <= '0;
    end else if (i_load) begin
      r_key <= i_key;
      r_rnd <= 5'd1;
    end else if (i_fwd) begin
      r_key <= key_upd(r_key, r_rnd);
      r_rnd <= (r_rnd == ROUNDS) ? r_rnd : r_rnd + 5'd1;
`ifdef PRESENT_DEC_EN
    end else if (i_bwd) begin
      r_key <= w_key_inv;
      r_rnd <= r_rnd - 5'd1;
`endif
    end
  end

endmodule

// File: rtl/present80_core.sv
// Round-iterative PRESENT-80 core; one operation per reset release.
// PRESENT_DEC_EN enables the decryption datapath.
//
//   state  | meaning
//   LOAD   | capture block/key, pick direction
//   KEYEXP | run key schedule forward to K32 (decrypt)
//   XOR0   | whiten with K32 (decrypt)
//   ROUND  | one cipher round, forward or inverse
//   FINAL  | final key whitening (encrypt)
//   DONE   | hold result, raise end flag
module present80_core
  import present_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  present80_core_if.slave bus
);

  fsm_e               r_fsm, w_fsm_nxt;
  logic [BLOCK_W-1:0] r_state, w_state_nxt;
  logic               r_end_enc, r_end_dec;
  logic               w_load, w_fwd;
  logic [BLOCK_W-1:0] w_rk;
  logic [4:0]         w_rnd;

`ifdef PRESENT_DEC_EN
  logic               w_bwd;
  logic [BLOCK_W-1:0] w_rk_inv;
`endif

  present80_key_sched u_key_sched (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_load),
    .i_fwd    (w_fwd),
`ifdef PRESENT_DEC_EN
    .i_bwd    (w_bwd),
    .o_rk_inv (w_rk_inv),
`endif
    .i_key    (bus.key_i),
    .o_rk     (w_rk),
    .o_rnd    (w_rnd)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fsm     <= LOAD;
      r_state   <= '0;
      r_end_enc <= 1'b0;
      r_end_dec <= 1'b0;
    end else begin
      r_fsm     <= w_fsm_nxt;
      r_state   <= w_state_nxt;
      r_end_enc <= (r_fsm == DONE) & ~bus.encdec_i;
      r_end_dec <= (r_fsm == DONE) & bus.encdec_i;
    end
  end

  always_comb begin
    w_fsm_nxt   = r_fsm;
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_fwd       = 1'b0;
`ifdef PRESENT_DEC_EN
    w_bwd       = 1'b0;
`endif
    case (r_fsm)
      LOAD: begin
        w_load      = 1'b1;
        w_state_nxt = bus.block_i;
        if (!bus.encdec_i) begin
          w_fsm_nxt = ROUND;
        end else begin
`ifdef PRESENT_DEC_EN
          w_fsm_nxt = KEYEXP;
`else
          // no decrypt hardware: finish at once with a zero result
          w_fsm_nxt   = DONE;
          w_state_nxt = '0;
`endif
        end
      end
`ifdef PRESENT_DEC_EN
      KEYEXP: begin
        w_fwd = 1'b1;
        if (w_rnd == ROUNDS) w_fsm_nxt = XOR0;
      end
      XOR0: begin
        w_state_nxt = r_state ^ w_rk;
        w_fsm_nxt   = ROUND;
      end
`endif
      ROUND: begin
        if (!bus.encdec_i) begin
          w_fwd       = 1'b1;
          w_state_nxt = p_layer(s_layer(r_state ^ w_rk));
          if (w_rnd == ROUNDS) w_fsm_nxt = FINAL;
        end else begin
`ifdef PRESENT_DEC_EN
          w_bwd       = 1'b1;
          w_state_nxt = s_inv_layer(p_inv_layer(r_state)) ^ w_rk_inv;
          if (w_rnd == 5'd1) w_fsm_nxt = DONE;
`else
          w_fsm_nxt = DONE;
`endif
        end
      end
      FINAL: begin
        w_state_nxt = r_state ^ w_rk;
        w_fsm_nxt   = DONE;
      end
      DONE: w_fsm_nxt = DONE;
      default: w_fsm_nxt = LOAD;
    endcase
  end

  assign bus.block_o = r_state;
  assign bus.end_enc = r_end_enc;
  assign bus.end_dec = r_end_dec;

endmodule

// File: tb/tb_present80_core.sv
// Self-checking bench for present80_core: known vectors, random operations against a
// textbook PRESENT model, latency and abort checks. Follows the PRESENT_DEC_EN build.
module tb_present80_core;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  present80_core_if bus();

  present80_core dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

`ifdef PRESENT_DEC_EN
  localparam bit DEC_EN  = 1'b1;
  localparam int DEC_LAT = 65;
`else
  localparam bit DEC_EN  = 1'b0;
  localparam int DEC_LAT = 2;
`endif

  // ---------------- reference model ----------------
  function automatic logic [3:0] f_sbox(input logic [3:0] v);
    case (v)
      4'h0: return 4'hC;  4'h1: return 4'h5;  4'h2: return 4'h6;  4'h3: return 4'hB;
      4'h4: return 4'h9;  4'h5: return 4'h0;  4'h6: return 4'hA;  4'h7: return 4'hD;
      4'h8: return 4'h3;  4'h9: return 4'hE;  4'hA: return 4'hF;  4'hB: return 4'h8;
      4'hC: return 4'h4;  4'hD: return 4'h7;  4'hE: return 4'h1;  default: return 4'h2;
    endcase
  endfunction

  function automatic logic [3:0] f_sbox_inv(input logic [3:0] v);
    logic [3:0] r;
    r = '0;
    for (int x = 0; x < 16; x++) if (f_sbox(4'(x)) == v) r = 4'(x);
    return r;
  endfunction

  function automatic int perm_dst(input int b);
    return (b == 63) ? 63 : (b * 16) % 63;
  endfunction

  function automatic logic [79:0] next_key(input logic [79:0] k, input int r);
    logic [79:0] t;
    t = {k[18:0], k[79:19]};
    t[79:76] = f_sbox(t[79:76]);
    t[19:15] = t[19:15] ^ 5'(r);
    return t;
  endfunction

  function automatic logic [63:0] model_enc(input logic [63:0] pt, input logic [79:0] key);
    logic [79:0] k;
    logic [63:0] s, t;
    k = key;
    s = pt;
    for (int r = 1; r <= 31; r++) begin
      s = s ^ k[79:16];
      for (int n = 0; n < 16; n++) s[6'(4 * n) +: 4] = f_sbox(s[6'(4 * n) +: 4]);
      t = '0;
      for (int b = 0; b < 64; b++) t[6'(perm_dst(b))] = s[6'(b)];
      s = t;
      k = next_key(k, r);
    end
    return s ^ k[79:16];
  endfunction

  function automatic logic [63:0] model_dec(input logic [63:0] ct, input logic [79:0] key);
    logic [79:0] rk [33];
    logic [63:0] s, t;
    rk[0] = '0;
    rk[1] = key;
    for (int r = 1; r <= 31; r++) rk[6'(r + 1)] = next_key(rk[6'(r)], r);
    s = ct ^ rk[32][79:16];
    for (int r = 31; r >= 1; r--) begin
      t = '0;
      for (int b = 0; b < 64; b++) t[6'(b)] = s[6'(perm_dst(b))];
      for (int n = 0; n < 16; n++) t[6'(4 * n) +: 4] = f_sbox_inv(t[6'(4 * n) +: 4]);
      s = t ^ rk[6'(r)][79:16];
    end
    return s;
  endfunction

  // ---------------- stimulus driver (measures, does not judge) ----------------
  task automatic run_op(input logic [63:0] blk, input logic [79:0] key, input logic dec,
                        output int lat, output logic [63:0] res, output logic [63:0] pre,
                        output logic other_seen, output logic [63:0] res_late,
                        output logic flag_late);
    logic sel, oth;
    lat = 0; res = '0; pre = '0; other_seen = 1'b0; res_late = '0; flag_late = 1'b0;
    rst = 1'b1;
    bus.block_i  = blk;
    bus.key_i    = key;
    bus.encdec_i = dec;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int e = 1; e <= 200; e++) begin
      @(posedge clk);
      #1;
      sel = dec ? bus.end_dec : bus.end_enc;
      oth = dec ? bus.end_enc : bus.end_dec;
      if (oth) other_seen = 1'b1;
      if (lat == 0) begin
        if (sel) begin
          lat = e;
          res = bus.block_o;
        end else begin
          pre = bus.block_o;
        end
      end else if (e == lat + 3) begin
        res_late  = bus.block_o;
        flag_late = sel;
        break;
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    rst = 1'b1;
    bus.block_i = 64'hDEAD_BEEF_0123_4567;
    bus.key_i = 80'h1;
    bus.encdec_i = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++; if (bus.block_o !== 64'h0) begin n_err++; $display("FAIL reset_block_o: got %h want 0", bus.block_o); end
    n_vec++; if (bus.end_enc !== 1'b0) begin n_err++; $display("FAIL reset_end_enc: got %b want 0", bus.end_enc); end
    n_vec++; if (bus.end_dec !== 1'b0) begin n_err++; $display("FAIL reset_end_dec: got %b want 0", bus.end_dec); end
  endtask

  task automatic test_enc_vectors;
    logic [63:0] pts [4];
    logic [79:0] keys [4];
    logic [63:0] exps [4];
    int lat; logic [63:0] res, pre, late; logic oth, fl;
    pts[0] = 64'h0;                 keys[0] = 80'h0;                  exps[0] = 64'h5579C1387B228445;
    pts[1] = 64'h0;                 keys[1] = 80'hFFFF_FFFFFFFF_FFFFFFFF; exps[1] = 64'hE72C46C0F5945049;
    pts[2] = 64'hFFFFFFFFFFFFFFFF;  keys[2] = 80'h0;                  exps[2] = 64'hA112FFC72F68417B;
    pts[3] = 64'hFFFFFFFFFFFFFFFF;  keys[3] = 80'hFFFF_FFFFFFFF_FFFFFFFF; exps[3] = 64'h3333DCD3213210D2;
    for (int v = 0; v < 4; v++) begin
      run_op(pts[v], keys[v], 1'b0, lat, res, pre, oth, late, fl);
      n_vec++; if (lat != 34) begin n_err++; $display("FAIL enc_vec%0d_latency: got %0d want 34", v, lat); end
      n_vec++; if (res !== exps[v]) begin n_err++; $display("FAIL enc_vec%0d_result: got %h want %h", v, res, exps[v]); end
      n_vec++; if (pre !== exps[v]) begin n_err++; $display("FAIL enc_vec%0d_early: got %h want %h", v, pre, exps[v]); end
      n_vec++; if (oth !== 1'b0) begin n_err++; $display("FAIL enc_vec%0d_end_dec: got %b want 0", v, oth); end
      n_vec++; if (late !== exps[v] || fl !== 1'b1) begin
        n_err++; $display("FAIL enc_vec%0d_hold: got %h/%b want %h/1", v, late, fl, exps[v]);
      end
    end
  endtask

  task automatic test_dec_vector;
    int lat; logic [63:0] res, pre, late, exp_res; logic oth, fl;
    exp_res = DEC_EN ? 64'hFFFFFFFFFFFFFFFF : 64'h0;
    run_op(64'h3333DCD3213210D2, 80'hFFFF_FFFFFFFF_FFFFFFFF, 1'b1, lat, res, pre, oth, late, fl);
    n_vec++; if (lat != DEC_LAT) begin n_err++; $display("FAIL dec_vec_latency: got %0d want %0d", lat, DEC_LAT); end
    n_vec++; if (res !== exp_res) begin n_err++; $display("FAIL dec_vec_result: got %h want %h", res, exp_res); end
    n_vec++; if (pre !== exp_res) begin n_err++; $display("FAIL dec_vec_early: got %h want %h", pre, exp_res); end
    n_vec++; if (oth !== 1'b0) begin n_err++; $display("FAIL dec_vec_end_enc: got %b want 0", oth); end
    n_vec++; if (late !== exp_res || fl !== 1'b1) begin
      n_err++; $display("FAIL dec_vec_hold: got %h/%b want %h/1", late, fl, exp_res);
    end
  endtask

  task automatic test_random_enc;
    int lat; logic [63:0] pt, res, pre, late, exp_res; logic [79:0] key; logic oth, fl;
    for (int v = 0; v < 5; v++) begin
      pt  = {$urandom, $urandom};
      key = 80'({$urandom, $urandom, $urandom});
      exp_res = model_enc(pt, key);
      run_op(pt, key, 1'b0, lat, res, pre, oth, late, fl);
      n_vec++; if (lat != 34) begin n_err++; $display("FAIL rnd_enc%0d_latency: got %0d want 34", v, lat); end
      n_vec++; if (res !== exp_res) begin n_err++; $display("FAIL rnd_enc%0d_result: got %h want %h", v, res, exp_res); end
      n_vec++; if (oth !== 1'b0) begin n_err++; $display("FAIL rnd_enc%0d_end_dec: got %b want 0", v, oth); end
    end
  endtask

  task automatic test_random_dec;
    int lat; logic [63:0] pt, ct, res, pre, late, exp_res; logic [79:0] key; logic oth, fl;
    for (int v = 0; v < 3; v++) begin
      pt  = {$urandom, $urandom};
      key = 80'({$urandom, $urandom, $urandom});
      ct  = model_enc(pt, key);
      exp_res = DEC_EN ? model_dec(ct, key) : 64'h0;
      run_op(ct, key, 1'b1, lat, res, pre, oth, late, fl);
      n_vec++; if (lat != DEC_LAT) begin n_err++; $display("FAIL rnd_dec%0d_latency: got %0d want %0d", v, lat, DEC_LAT); end
      n_vec++; if (res !== exp_res) begin n_err++; $display("FAIL rnd_dec%0d_result: got %h want %h", v, res, exp_res); end
      n_vec++; if (DEC_EN && res !== pt) begin n_err++; $display("FAIL rnd_dec%0d_roundtrip: got %h want %h", v, res, pt); end
      n_vec++; if (oth !== 1'b0) begin n_err++; $display("FAIL rnd_dec%0d_end_enc: got %b want 0", v, oth); end
    end
  endtask

  task automatic test_reset_mid_op;
    int lat; logic [63:0] res, pre, late; logic oth, fl;
    rst = 1'b1;
    bus.block_i  = 64'h3333DCD3213210D2;
    bus.key_i    = 80'hFFFF_FFFFFFFF_FFFFFFFF;
    bus.encdec_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    n_vec++; if (bus.block_o !== 64'h0) begin n_err++; $display("FAIL abort_block_o: got %h want 0", bus.block_o); end
    n_vec++; if (bus.end_enc !== 1'b0 || bus.end_dec !== 1'b0) begin
      n_err++; $display("FAIL abort_flags: got %b%b want 00", bus.end_enc, bus.end_dec);
    end
    run_op(64'h0, 80'h0, 1'b0, lat, res, pre, oth, late, fl);
    n_vec++; if (lat != 34) begin n_err++; $display("FAIL abort_rerun_latency: got %0d want 34", lat); end
    n_vec++; if (res !== 64'h5579C1387B228445) begin
      n_err++; $display("FAIL abort_rerun_result: got %h want 5579c1387b228445", res);
    end
  endtask

  initial begin
    bus.block_i  = '0;
    bus.key_i    = '0;
    bus.encdec_i = 1'b0;
    test_reset();
    test_enc_vectors();
    test_dec_vector();
    test_random_enc();
    test_random_dec();
    test_reset_mid_op();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/present80_core.md
# present80_core

Round-iterative PRESENT-80 block cipher core: the unit under test driven by `autotest_module`. It runs from `clk_uut` and uses `rst_uut` as its reset. It starts one encryption or decryption on each reset release. It raises the matching end flag when the result is valid; the external performance counter counts while that flag is low.

## Interface
- No parameters. Block width is fixed at 64 bits, key width at 80 bits, and round count at 31.
- `clk` in 1: core clock, driven by `clk_uut`.
- `rst` in 1: asynchronous, active-high reset, driven by `rst_uut`. Each deassertion starts a new operation.
- `block_i` in 64: plaintext or ciphertext. Must be stable from reset deassertion until the end flag is high.
- `key_i` in 80: cipher key. Same stability rule as `block_i`.
- `encdec_i` in 1: 0 selects encryption, 1 selects decryption. Same stability rule.
- `block_o` out 64: result. Valid only while `end_enc` or `end_dec` is high.
- `end_enc` out 1: encryption done. Sticky until reset.
- `end_dec` out 1: decryption done. Sticky until reset.

## Operation
- Registers:
  - `state` (64)
  - `key` (80)
  - `rnd` (5)
  - `fsm`
- FSM states: `LOAD`, `KEYEXP`, `XOR0`, `ROUND`, `FINAL`, `DONE`. Reset state is `LOAD`.
- `LOAD`:
  - `state <= block_i`, `key <= key_i`, `rnd <= 1`.
  - If `encdec_i = 0`, go to `ROUND`; otherwise go to `KEYEXP`.
- Encryption `ROUND`:
  - `state <= P(S(state ^ key[79:16]))`, `key <= upd(key, rnd)`, `rnd++`.
  - After the cycle with `rnd = 31`, go to `FINAL`.
- `FINAL`: `state <= state ^ key[79:16]`, then go to `DONE`.
- `KEYEXP` (decryption only):
  - `key <= upd(key, rnd)`, `rnd++`.
  - After `rnd = 31`, `key` holds K32; set `rnd <= 31` and go to `XOR0`.
- `XOR0`: `state <= state ^ key[79:16]`, then go to decryption `ROUND`.
- Decryption `ROUND`:
  - `k' = inv(key, rnd)`, `state <= Sinv(Pinv(state)) ^ k'[79:16]`, `key <= k'`, `rnd--`.
  - After `rnd = 1`, go to `DONE`.
- `upd(K, r)`:
  - rotate `K` left by 61;
  - `K[79:76] = S(K[79:76])`;
  - `K[19:15] ^= r`.
- `inv(K, r)`: exact inverse of `upd`. XOR `r` into `K[19:15]`, apply `Sinv` to `K[79:76]`, then rotate right by 61.
- `P`: bit `i` moves to `16*i mod 63`; bit 63 is fixed.
- `DONE`:
  - Registers hold.
  - `end_enc = (fsm == DONE) & !encdec_i`, `end_dec = (fsm == DONE) & encdec_i`, both registered.
  - The flag not selected by `encdec_i` is never asserted.
- `block_o` is wired directly to `state`.
- Reset asserted mid-operation: all registers clear immediately and the operation is lost. A new operation starts on reset release.

## Timing
- Reset values:
  - `block_o = 0`, `end_enc = 0`, `end_dec = 0`.
  - `state = 0`, `key = 0`, `rnd = 0`, `fsm = LOAD`.
- Encryption: the end flag rises after rising edge 34 following reset deassertion. That is LOAD (1) + ROUND (31) + FINAL (1) + flag register (1). The performance counter reads 34.
- Decryption: the end flag rises after edge 65. That is LOAD (1) + KEYEXP (31) + XOR0 (1) + ROUND (31) + flag register (1). The performance counter reads 65.
- `block_o` is final one cycle before the end flag rises and stays stable while the flag is high.
- No back-pressure and no start pulse; reset release is the only trigger.

## Configuration
- `PRESENT_DEC_EN` defined:
  - Full decryption path present: `KEYEXP`, `XOR0`, inverse S-box, inverse permutation, `inv`.
- `PRESENT_DEC_EN` undefined:
  - Decryption logic is removed.
  - With `encdec_i = 1`, `LOAD` goes straight to `DONE` and `state` is forced to 0.
  - `end_dec` rises after edge 2 with `block_o = 64'h0`, so the harness never hangs.
  - Encryption behaviour is unchanged.

## Structure
- `present_pkg`:
  - constants `SBOX[16]`, `SBOX_INV[16]`;
  - localparams `ROUNDS = 31`, `BLOCK_W = 64`, `KEY_W = 80`;
  - FSM state enum;
  - functions `s_layer`, `s_inv_layer`, `p_layer`, `p_inv_layer`, `key_upd`, `key_inv`.
- Sub-module `present80_key_sched` holds the `key` register and `rnd` counter.
  - Controls: `load`, `fwd`, `bwd`.
  - Outputs: current round key `key[79:16]` and the inverse-stepped key.
  - The core instantiates it once.

## Test plan
- Encrypt `block_i = 0`, `key_i = 0` -> `block_o = 64'h5579C1387B228445`, `end_enc` rises after edge 34, `end_dec` stays 0.
- Encrypt `block_i = 0`, `key_i = 80'hFFFF_FFFFFFFF_FFFFFFFF` -> `64'hE72C46C0F5945049`.
- Encrypt `block_i = 64'hFFFFFFFFFFFFFFFF`, `key_i = 0` -> `64'hA112FFC72F68417B`. Encrypt all-ones block with all-ones key -> `64'h3333DCD3213210D2`.
- Decrypt `64'h3333DCD3213210D2` with all-ones key -> `64'hFFFFFFFFFFFFFFFF`, `end_dec` rises after edge 65, `end_enc` stays 0.
- Assert `rst` at edge 20 of a decryption -> outputs 0 immediately. Re-run as encryption with `block_i = 0`, `key_i = 0` -> `64'h5579C1387B228445` after 34 edges.
- Build without `PRESENT_DEC_EN`, `encdec_i = 1` -> `end_dec` rises after edge 2 with `block_o = 0`.
